// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with a zero-fill clear sequencer.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  output logic            busy,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr0,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [DEPTH];
  logic            wr0;
  logic            wr1;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr0 = we0 && !is_zero_reg(waddr0);
  assign wr1 = we1 && !is_zero_reg(waddr1);

  // Clear sequencer: one entry per edge, READY after the last index is written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage is untouched during reset; port 1 is written last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else begin
        if (wr0) mem[waddr0] <= wdata0;
        if (wr1) mem[waddr1] <= wdata1;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    d = mem[a];
`ifdef RF_BYPASS_EN
    if (wr0 && waddr0 == a) d = wdata0;
    if (wr1 && waddr1 == a) d = wdata1;
`endif
    if (busy || is_zero_reg(a)) d = '0;
    return d;
  endfunction

  always_comb begin
    rdata0 = read_port(raddr0);
    rdata1 = read_port(raddr1);
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32: data width in bits of every register and data port; SHALL be >= 8.
REQ-002 Parameter DEPTH, default 32: number of registers; SHALL be a power of two and >= 4.
REQ-003 Parameter AW, default $clog2(DEPTH): address width; SHALL be derived from DEPTH, not set independently.
REQ-004 Parameter ZERO_REG, default 1: 1 = register 0 is hardwired to zero; 0 = register 0 is a normal register.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 clr_req  input  1  request to zero-fill all registers; sampled only in READY.
REQ-008 busy  output  1  high while the clear sequencer is in CLEAR.
REQ-009 we0 / we1  input  1 each  write enables for write ports 0 and 1.
REQ-010 waddr0 / waddr1  input  AW each  write addresses.
REQ-011 wdata0 / wdata1  input  XLEN each  write data.
REQ-012 raddr0 / raddr1  input  AW each  read addresses.
REQ-013 rdata0 / rdata1  output  XLEN each  read data; combinational from raddr and storage.

Function
REQ-014 Sequencer states SHALL be CLEAR and READY, plus a clear index clr_idx of AW bits.
REQ-015 CLEAR: each rising edge writes 0 to entry clr_idx and increments clr_idx; when clr_idx == DEPTH-1 is written, the next state is READY.
REQ-016 READY with clr_req=1 on an edge: next state CLEAR, clr_idx=0; any write on that same edge is still performed.
REQ-017 clr_req SHALL be ignored while in CLEAR; there is no queuing or restart.
REQ-018 While busy=1, we0/we1 are ignored and rdata0/rdata1 SHALL read as 0.
REQ-019 In READY, a port with weN=1 writes wdataN to entry waddrN on the rising edge, for a one-cycle write latency.
REQ-020 If both write ports target the same address on the same edge, port 1 SHALL win and port 0's data SHALL be discarded.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be dropped, and reads of address 0 SHALL return 0 in all states.
REQ-022 Reads SHALL be asynchronous with zero-cycle latency; with RF_BYPASS_EN undefined, a read in the cycle of a write to the same address returns the old value.
REQ-023 Read ports SHALL be independent; both may read the same address.

Reset
REQ-024 While rst_n=0 on a rising edge: state=CLEAR, clr_idx=0, busy=1, and rdata0=rdata1=0; storage contents are not otherwise touched.
REQ-025 After rst_n rises, busy SHALL remain high for exactly DEPTH rising edges, then go low with all entries equal to 0.
REQ-026 rst_n=0 mid-CLEAR or mid-operation SHALL restart the clear from clr_idx=0.
REQ-027 The block SHALL not load any memory initialisation file.

Configuration
REQ-028 When macro RF_BYPASS_EN is defined, a read in READY whose raddr matches an active write address SHALL return that write's wdata in the same cycle. Port 1 has priority when both writes match. Address 0 with ZERO_REG=1 still reads 0.
REQ-029 When RF_BYPASS_EN is undefined, there is no forwarding path and REQ-022 applies.

Verification
REQ-030 DEPTH=32, XLEN=32: hold rst_n=0 for 3 cycles, then release. Required: busy=1 for exactly 32 edges; then rdata0 reads 0 for all 32 addresses.
REQ-031 READY: we0=1, waddr0=5, wdata0=0xDEADBEEF for one edge. Required: raddr1=5 returns 0xDEADBEEF from the next cycle onward.
REQ-032 Same edge: we0=1 (addr 7, 0x11111111) and we1=1 (addr 7, 0x22222222). Required: addr 7 reads 0x22222222.
REQ-033 ZERO_REG=1: write 0xFFFFFFFF to address 0. Required: rdata0 reads 0. With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
REQ-034 Registers 3 and 9 are nonzero; pulse clr_req for one edge, and assert rst_n=0 at clr_idx=10. Required: the clear restarts at index 0, busy stays high for 32 edges after release, and all entries read 0.
REQ-035 RF_BYPASS_EN defined: we1=1, waddr1=12, wdata1=0xA5A5A5A5, with raddr0=12 in the same cycle. Required: rdata0=0xA5A5A5A5 before the edge. With the macro undefined, rdata0 shows the old value.
